// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives all datapath strobes; memory states stall until MemReady.
module mc_main_control #(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state, nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  assign State = state;

  always_comb begin
    nxt         = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    IllegalOp   = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        nxt     = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU computes the branch target speculatively while Op is decoded
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI: begin
            if (ADDI_EN) nxt = ADDIEX;
            else         IllegalOp = 1'b1;
          end
          default:      IllegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (Op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        nxt      = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: instruction-level model expands each opcode
// into its expected per-cycle state/strobe trace; a monitor compares every cycle.
module tb_mc_main_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [2];
  logic [5:0] op_a  [2];
  logic       rdy_a [2];

  logic [16:0] ov [2];
  logic [3:0]  st [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, il;
    logic [1:0] pcs, aop, asb;
    mc_main_control #(.ADDI_EN(g == 1)) dut (
      .clk(clk), .reset(rst_a[g]), .Op(op_a[g]), .MemReady(rdy_a[g]),
      .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd),
      .MemWrite(mwr), .MemtoReg(m2r), .IRWrite(irw), .PCSource(pcs),
      .ALUOp(aop), .ALUSrcA(asa), .ALUSrcB(asb), .RegWrite(rw),
      .RegDst(rd), .IllegalOp(il), .State(st[g])
    );
    assign ov[g] = {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, il};
  end

  typedef struct packed {
    logic        chk;
    logic [3:0]  st;
    logic [16:0] o;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   nvec = 0;
  int   nerr = 0;

  // Strobe table, written straight from the per-state output list.
  function automatic logic [16:0] exp_o(int s, bit r, bit ill);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, il;
    logic [1:0] pcs, aop, asb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, il} = '0;
    {pcs, aop, asb} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = r; pcw = r; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, il};
  endfunction

  task automatic cyc(input int id, input int s, input bit rdy, input logic [5:0] opv,
                     input bit rs, input bit ill, input bit chk);
    rec_t r;
    @(posedge clk);
    #1;
    rst_a[id] = rs;
    op_a[id]  = opv;
    rdy_a[id] = rdy;
    r.chk = chk;
    r.st  = 4'(s);
    r.o   = exp_o(s, rdy, ill);
    if (id == 0) q0.push_back(r);
    else         q1.push_back(r);
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  // Memory state with 'w' stall cycles; abort >= 0 asserts reset on that stall cycle.
  task automatic mem_state(input int id, input int s, input int w, input int abort,
                           output bit aborted);
    aborted = 0;
    for (int i = 0; i < w; i++) begin
      if (abort == i) begin
        cyc(id, s, 1'b0, rop(), 1'b1, 1'b0, 1'b1);
        aborted = 1;
        return;
      end
      cyc(id, s, 1'b0, rop(), 1'b0, 1'b0, 1'b1);
    end
    cyc(id, s, 1'b1, rop(), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_instr(input int id, input logic [5:0] op, input int fw,
                           input int mw, input int abort);
    bit ab;
    bit addi_ok = (id == 1);
    bit legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000 && addi_ok);
    for (int i = 0; i < fw; i++) cyc(id, 0, 1'b0, rop(), 1'b0, 1'b0, 1'b1);
    cyc(id, 0, 1'b1, rop(), 1'b0, 1'b0, 1'b1);
    cyc(id, 1, 1'($urandom), op, 1'b0, !legal, 1'b1);
    if (!legal) return;
    case (op)
      6'b100011: begin
        cyc(id, 2, 1'($urandom), op, 1'b0, 1'b0, 1'b1);
        mem_state(id, 3, mw, abort, ab);
        if (!ab) cyc(id, 4, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
      end
      6'b101011: begin
        cyc(id, 2, 1'($urandom), op, 1'b0, 1'b0, 1'b1);
        mem_state(id, 5, mw, abort, ab);
      end
      6'b000000: begin
        cyc(id, 6, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
        cyc(id, 7, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
      end
      6'b000100: cyc(id, 8, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
      6'b000010: cyc(id, 9, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
      default: begin
        cyc(id, 10, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
        cyc(id, 11, 1'($urandom), rop(), 1'b0, 1'b0, 1'b1);
      end
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    logic [5:0] o;
    int k;
    legal[0] = 6'b100011; legal[1] = 6'b101011; legal[2] = 6'b000000;
    legal[3] = 6'b000100; legal[4] = 6'b000010; legal[5] = 6'b001000;
    k = int'($urandom_range(0, 6));
    if (k < 6) return legal[k];
    do o = rop();
    while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b000010 || o == 6'b001000);
    return o;
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (q0.size() > 0) begin
      r = q0.pop_front();
      if (r.chk) begin
        nvec++;
        if (st[0] !== r.st || ov[0] !== r.o) begin
          nerr++;
          $display("FAIL dut0(addi off) state/strobes: got st=%0d o=%h, want st=%0d o=%h",
                   st[0], ov[0], r.st, r.o);
        end
      end
    end
    if (q1.size() > 0) begin
      r = q1.pop_front();
      if (r.chk) begin
        nvec++;
        if (st[1] !== r.st || ov[1] !== r.o) begin
          nerr++;
          $display("FAIL dut1(addi on) state/strobes: got st=%0d o=%h, want st=%0d o=%h",
                   st[1], ov[1], r.st, r.o);
        end
      end
    end
  end

  initial begin
    int mw, ab;
    logic [5:0] op;
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; op_a[i] = '0; rdy_a[i] = 1'b1;
    end
    // Two reset cycles; state is unknown before the first edge
    cyc(1, 0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1);
    // Directed: R, lw with 3 stalls, sw aborted by reset, beq, j, illegal, addi
    run_instr(1, 6'b000000, 0, 0, -1);
    run_instr(1, 6'b100011, 1, 3, -1);
    run_instr(1, 6'b101011, 0, 4, 2);
    run_instr(1, 6'b000100, 0, 0, -1);
    run_instr(1, 6'b000010, 2, 0, -1);
    run_instr(1, 6'b111111, 0, 0, -1);
    run_instr(1, 6'b001000, 0, 0, -1);
    run_instr(1, 6'b101011, 0, 2, -1);
    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      op = pick_op();
      mw = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4));
      ab = (mw > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, mw - 1)) : -1;
      run_instr(1, op, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0, mw, ab);
    end
    // Variant without addi support
    cyc(0, 0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1);
    run_instr(0, 6'b001000, 0, 0, -1);
    run_instr(0, 6'b111111, 0, 0, -1);
    run_instr(0, 6'b000000, 1, 0, -1);
    run_instr(0, 6'b001000, 0, 0, -1);
    run_instr(0, 6'b100011, 0, 2, -1);
    run_instr(0, 6'b000010, 0, 0, -1);
    repeat (3) @(posedge clk);
    nvec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard drain: got %0d/%0d left, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
